// File: rtl/adder_8_err_monitor_if.sv
// adder_8_err_monitor_if: sample input and report output bundle for adder_8_err_monitor
// Max-error report signals exist only when ADDER8_MON_MAXERR_EN is defined.
interface adder_8_err_monitor_if #(parameter int CNT_W = 16);
    logic in_valid;
    logic in_ready;
    logic [6:0] pi;
    logic [3:0] po_apx;
    logic [3:0] po_ref;
    logic rep_valid;
    logic rep_ready;
    logic [CNT_W-1:0] rep_err_cnt;
    logic [CNT_W+3:0] rep_abs_sum;
    logic [CNT_W+2:0] rep_ham_sum;
`ifdef ADDER8_MON_MAXERR_EN
    logic [3:0] rep_max_err;
    logic [6:0] rep_max_pi;
    modport master(output in_valid, pi, po_apx, po_ref, rep_ready,
                   input in_ready, rep_valid, rep_err_cnt, rep_abs_sum, rep_ham_sum, rep_max_err, rep_max_pi);
    modport slave(input in_valid, pi, po_apx, po_ref, rep_ready,
                  output in_ready, rep_valid, rep_err_cnt, rep_abs_sum, rep_ham_sum, rep_max_err, rep_max_pi);
`else
    modport master(output in_valid, pi, po_apx, po_ref, rep_ready,
                   input in_ready, rep_valid, rep_err_cnt, rep_abs_sum, rep_ham_sum);
    modport slave(input in_valid, pi, po_apx, po_ref, rep_ready,
                  output in_ready, rep_valid, rep_err_cnt, rep_abs_sum, rep_ham_sum);
`endif
endinterface

// File: rtl/adder_8_err_monitor.sv
// adder_8_err_monitor: windowed error statistics of approximate vs exact adder_8 results
// Define ADDER8_MON_MAXERR_EN to also report the window's max error and its operand vector.
module adder_8_err_monitor #(
    parameter int WINDOW = 128,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    input logic en,
    input logic clr,
    adder_8_err_monitor_if.slave m
);
    localparam int AW = CNT_W + 4;
    localparam int HW = CNT_W + 3;
    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] sample_cnt, err_cnt, err_nxt;
    logic [AW-1:0] abs_sum, abs_nxt;
    logic [HW-1:0] ham_sum, ham_nxt;
    logic [3:0] x, diff;
    logic acc, last;
    assign m.in_ready = state == ACCUM && !clr;
    assign m.rep_valid = state == REPORT;
    always_comb begin
        x = m.po_apx ^ m.po_ref;
        diff = m.po_apx >= m.po_ref ? m.po_apx - m.po_ref : m.po_ref - m.po_apx;
        acc = m.in_valid && state == ACCUM && !clr;
        last = sample_cnt == CNT_W'(WINDOW - 1);
        err_nxt = err_cnt + CNT_W'(x != 4'd0);
        abs_nxt = abs_sum + AW'(diff);
        ham_nxt = ham_sum + HW'(x[0]) + HW'(x[1]) + HW'(x[2]) + HW'(x[3]);
    end
    // clr outranks both a sample and a report handshake
    always_comb begin
        state_nxt = state;
        if (clr || state == IDLE) state_nxt = en ? ACCUM : IDLE;
        else if (state == ACCUM) state_nxt = (acc && last) ? REPORT : (en ? ACCUM : IDLE);
        else if (m.rep_ready) state_nxt = en ? ACCUM : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt <= '0;
            abs_sum <= '0;
            ham_sum <= '0;
            m.rep_err_cnt <= '0;
            m.rep_abs_sum <= '0;
            m.rep_ham_sum <= '0;
        end else begin
            if (clr || (acc && last)) begin
                sample_cnt <= '0;
                err_cnt <= '0;
                abs_sum <= '0;
                ham_sum <= '0;
            end else if (acc) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
                err_cnt <= err_nxt;
                abs_sum <= abs_nxt;
                ham_sum <= ham_nxt;
            end
            if (acc && last) begin
                m.rep_err_cnt <= err_nxt;
                m.rep_abs_sum <= abs_nxt;
                m.rep_ham_sum <= ham_nxt;
            end
        end
    end
`ifdef ADDER8_MON_MAXERR_EN
    logic [3:0] max_err;
    logic [6:0] max_pi;
    logic take;
    // first sample of a window always seeds the max; later ties keep the earlier pi
    assign take = sample_cnt == '0 || diff > max_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_err <= '0;
            max_pi <= '0;
            m.rep_max_err <= '0;
            m.rep_max_pi <= '0;
        end else begin
            if (clr || (acc && last)) begin
                max_err <= '0;
                max_pi <= '0;
            end else if (acc && take) begin
                max_err <= diff;
                max_pi <= m.pi;
            end
            if (acc && last) begin
                m.rep_max_err <= take ? diff : max_err;
                m.rep_max_pi <= take ? m.pi : max_pi;
            end
        end
    end
`else
    logic unused_pi;
    assign unused_pi = ^m.pi;
`endif
endmodule

// File: tb/tb_adder_8_err_monitor.sv
// tb_adder_8_err_monitor: directed windows from a table, corner sequences, and a randomized
// run against a queue-based model of the window statistics.
module tb_adder_8_err_monitor;
    localparam int WINDOW = 4;
    localparam int CNT_W = 16;
    logic clk = 0, rst = 1, en = 0, clr = 0;
    int checks = 0, failures = 0;
    adder_8_err_monitor_if #(.CNT_W(CNT_W)) m();
    adder_8_err_monitor #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .en(en), .clr(clr), .m(m));
    always #5 clk = ~clk;

    typedef struct { logic [15:0] apx, rf; int err, abs_s, ham, mx, mi; } vec_t;
    typedef struct { int a, r, p; } smp_t;
    vec_t tbl[5];
    smp_t q[$];
    int e_err, e_abs, e_ham, e_mx, e_mpi;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pi_of(input int r, input int j);
        return 7'(r * 8 + j);
    endfunction

    task automatic send(input int r, input int j);
        int n = 0;
        m.in_valid = 1;
        m.po_apx = tbl[r].apx[4*j +: 4];
        m.po_ref = tbl[r].rf[4*j +: 4];
        m.pi = pi_of(r, j);
        @(negedge clk);
        while (!m.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", m.in_ready, 1);
        @(posedge clk);
        #1 m.in_valid = 0;
    endtask

    task automatic chk_rep(input int r);
        chk("rep_valid", m.rep_valid, 1);
        chk("rep_err_cnt", m.rep_err_cnt, tbl[r].err);
        chk("rep_abs_sum", m.rep_abs_sum, tbl[r].abs_s);
        chk("rep_ham_sum", m.rep_ham_sum, tbl[r].ham);
`ifdef ADDER8_MON_MAXERR_EN
        chk("rep_max_err", m.rep_max_err, tbl[r].mx);
        chk("rep_max_pi", m.rep_max_pi, pi_of(r, tbl[r].mi));
`endif
    endtask

    task automatic send_rec(input int r);
        for (int j = 0; j < WINDOW; j++) begin
            if (j == WINDOW - 1) chk("rep_early", m.rep_valid, 0);
            send(r, j);
        end
        chk_rep(r);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, m.in_ready, 0);
        chk({tag, "_rep_valid"}, m.rep_valid, 0);
        chk({tag, "_err_cnt"}, m.rep_err_cnt, 0);
        chk({tag, "_abs_sum"}, m.rep_abs_sum, 0);
        chk({tag, "_ham_sum"}, m.rep_ham_sum, 0);
`ifdef ADDER8_MON_MAXERR_EN
        chk({tag, "_max_err"}, m.rep_max_err, 0);
        chk({tag, "_max_pi"}, m.rep_max_pi, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // samples are nibbles, sample j at bits [4j+3:4j]
        tbl[0] = '{16'h9065, 16'h9F45, 2, 17, 5, 15, 2};
        tbl[1] = '{16'h0000, 16'h0000, 0, 0, 0, 0, 0};
        tbl[2] = '{16'h0F0F, 16'hF0F0, 4, 60, 16, 15, 0};
        tbl[3] = '{16'hC831, 16'hC712, 3, 4, 7, 2, 1};
        tbl[4] = '{16'h5A37, 16'hA573, 4, 18, 10, 5, 2};
        m.in_valid = 0;
        m.po_apx = 0;
        m.po_ref = 0;
        m.pi = 0;
        m.rep_ready = 1;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 0;
        en = 1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 5; r++) begin
            send_rec(r);
            @(posedge clk);
            #1 chk("rep_consumed", m.rep_valid, 0);
        end
        // backpressure: report held, upstream stalled
        m.rep_ready = 0;
        send_rec(0);
        m.in_valid = 1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", m.in_ready, 0);
            chk_rep(0);
        end
        m.rep_ready = 1;
        @(posedge clk);
        #1 m.in_valid = 0;
        chk("bp_released", m.rep_valid, 0);
        send_rec(1);
        @(posedge clk);
        #1;
        // clr mid-window with a coincident sample
        send(2, 0);
        send(2, 1);
        clr = 1;
        m.in_valid = 1;
        m.po_apx = 15;
        m.po_ref = 0;
        @(negedge clk);
        chk("clr_in_ready", m.in_ready, 0);
        @(posedge clk);
        #1 clr = 0;
        m.in_valid = 0;
        send_rec(3);
        @(posedge clk);
        #1;
        // clr discards an unconsumed report
        m.rep_ready = 0;
        send_rec(2);
        clr = 1;
        @(posedge clk);
        #1 clr = 0;
        chk("clr_drop", m.rep_valid, 0);
        m.rep_ready = 1;
        repeat (5) begin
            @(negedge clk);
            chk("clr_no_rep", m.rep_valid, 0);
        end
        @(posedge clk);
        #1 send_rec(4);
        @(posedge clk);
        #1;
        // partial window survives en=0
        for (int j = 0; j < 3; j++) send(0, j);
        en = 0;
        repeat (20) @(posedge clk);
        #1 chk("idle_in_ready", m.in_ready, 0);
        chk("idle_rep_valid", m.rep_valid, 0);
        en = 1;
        @(posedge clk);
        #1 send(0, 3);
        chk_rep(0);
        @(posedge clk);
        #1;
        // randomized run against the model
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        begin
            bit active = 0, pending = 0;
            q.delete();
            e_err = 0; e_abs = 0; e_ham = 0; e_mx = 0; e_mpi = 0;
            for (int c = 0; c < 3000; c++) begin
                int a, b, p;
                bit vin, rr, cl, exp_ready;
                a = $urandom_range(0, 15);
                b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 15);
                p = $urandom_range(0, 127);
                vin = $urandom_range(0, 3) != 0;
                rr = $urandom_range(0, 2) != 0;
                cl = $urandom_range(0, 40) == 0;
                m.in_valid = vin;
                m.po_apx = 4'(a);
                m.po_ref = 4'(b);
                m.pi = 7'(p);
                m.rep_ready = rr;
                clr = cl;
                @(negedge clk);
                exp_ready = active && !pending && !cl;
                chk("rnd_in_ready", m.in_ready, exp_ready);
                chk("rnd_rep_valid", m.rep_valid, pending);
                chk("rnd_err_cnt", m.rep_err_cnt, e_err);
                chk("rnd_abs_sum", m.rep_abs_sum, e_abs);
                chk("rnd_ham_sum", m.rep_ham_sum, e_ham);
`ifdef ADDER8_MON_MAXERR_EN
                chk("rnd_max_err", m.rep_max_err, e_mx);
                chk("rnd_max_pi", m.rep_max_pi, e_mpi);
`endif
                @(posedge clk);
                if (cl) begin
                    q.delete();
                    pending = 0;
                end else if (pending) begin
                    if (rr) pending = 0;
                end else if (exp_ready && vin) begin
                    q.push_back('{a, b, p});
                    if (q.size() == WINDOW) begin
                        e_err = 0; e_abs = 0; e_ham = 0; e_mx = 0; e_mpi = 0;
                        foreach (q[i]) begin
                            int d;
                            d = q[i].a > q[i].r ? q[i].a - q[i].r : q[i].r - q[i].a;
                            e_err += int'(d != 0);
                            e_abs += d;
                            e_ham += $countones(4'(q[i].a ^ q[i].r));
                            if (i == 0 || d > e_mx) begin
                                e_mx = d;
                                e_mpi = q[i].p;
                            end
                        end
                        pending = 1;
                        q.delete();
                    end
                end
                active = 1;
                #1;
            end
        end
        // async reset while a report is pending
        m.in_valid = 0;
        m.rep_ready = 0;
        clr = 1;
        @(posedge clk);
        #1 clr = 0;
        send_rec(0);
        #3 rst = 1;
        #1 chk_zero("async_rst");
        @(posedge clk);
        #1 rst = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
